// File: rtl/adder_4bit_full_adder.sv
// rtl/adder_4bit_full_adder.sv - one-bit full adder cell for the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/adder_4bit.sv
// rtl/adder_4bit.sv - registered 4-bit unsigned ripple-carry adder with carry-out
module adder_4bit (
  input  logic       iCLOCK,
  input  logic       inRESET_SYNC,
  input  logic [3:0] iDATA_A,
  input  logic [3:0] iDATA_B,
  output logic [3:0] oDATA,
  output logic       oC
);

  localparam int Width = 4;

  logic [Width:0]   carry;
  logic [Width-1:0] sumBits;
  logic [Width:0]   resultReg;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < Width; i++) begin : gRipple
    full_adder uFullAdder (
      .a (iDATA_A[i]),
      .b (iDATA_B[i]),
      .ci(carry[i]),
      .s (sumBits[i]),
      .co(carry[i+1])
    );
  end

  // Reset name is historical; the clear is asynchronous.
  always_ff @(posedge iCLOCK or negedge inRESET_SYNC) begin
    if (!inRESET_SYNC) begin
      resultReg <= '0;
    end else begin
      resultReg <= {carry[Width], sumBits};
    end
  end

  assign oDATA = resultReg[Width-1:0];
  assign oC    = resultReg[Width];

endmodule

// File: tb/tb_adder_4bit.sv
// tb/tb_adder_4bit.sv - self-checking bench for adder_4bit
module tb_adder_4bit;

  logic       iCLOCK = 1'b0;
  logic       inRESET_SYNC;
  logic [3:0] iDATA_A;
  logic [3:0] iDATA_B;
  logic [3:0] oDATA;
  logic       oC;

  int total = 0;
  int bad   = 0;

  adder_4bit dut (
    .iCLOCK      (iCLOCK),
    .inRESET_SYNC(inRESET_SYNC),
    .iDATA_A     (iDATA_A),
    .iDATA_B     (iDATA_B),
    .oDATA       (oDATA),
    .oC          (oC)
  );

  always #5 iCLOCK = ~iCLOCK;

  function automatic logic [4:0] refSum(input int a, input int b);
    int s;
    s = a + b;
    return s[4:0];
  endfunction

  task automatic check(input string tag, input logic [4:0] expected);
    logic [4:0] observed;
    observed = {oC, oDATA};
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b);
    @(negedge iCLOCK);
    iDATA_A = a;
    iDATA_B = b;
  endtask

  task automatic stepCheck(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [4:0] expected);
    drive(a, b);
    @(posedge iCLOCK);
    #1;
    check(tag, expected);
  endtask

  logic [4:0] prev;
  logic [3:0] ra;
  logic [3:0] rb;

  initial begin
    inRESET_SYNC = 1'b0;
    iDATA_A = 4'd3;
    iDATA_B = 4'd4;
    #1;
    check("reset_initial", 5'h00);
    for (int i = 0; i < 5; i++) begin
      @(posedge iCLOCK);
      #1;
      check("reset_hold", 5'h00);
    end
    @(negedge iCLOCK);
    inRESET_SYNC = 1'b1;
    @(posedge iCLOCK);
    #1;
    check("reset_release", 5'h07);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        stepCheck("sweep", 4'(a), 4'(b), refSum(a, b));
      end
    end

    stepCheck("carry_f_1", 4'hF, 4'h1, 5'h10);
    stepCheck("carry_8_8", 4'h8, 4'h8, 5'h10);
    stepCheck("nocarry_7_8", 4'h7, 4'h8, 5'h0F);
    stepCheck("max_f_f", 4'hF, 4'hF, 5'h1E);
    stepCheck("zero_after_max", 4'h0, 4'h0, 5'h00);

    stepCheck("hold_first", 4'hA, 4'h9, 5'h13);
    for (int i = 0; i < 3; i++) begin
      @(posedge iCLOCK);
      #1;
      check("hold_stable", 5'h13);
    end

    // New operands must not reach outputs before the next edge.
    for (int k = 1; k <= 3; k++) begin
      prev = {oC, oDATA};
      drive(4'(k), 4'(k));
      #1;
      check("latency_no_glitch", prev);
      @(posedge iCLOCK);
      #1;
      check("latency_sum", refSum(k, k));
    end

    for (int n = 0; n < 60; n++) begin
      ra = 4'($urandom_range(15, 0));
      rb = 4'($urandom_range(15, 0));
      stepCheck("random", ra, rb, refSum(int'(ra), int'(rb)));
      if (n == 30) begin
        #2;
        inRESET_SYNC = 1'b0;
        #1;
        check("async_reset_mid", 5'h00);
        @(negedge iCLOCK);
        #1;
        check("async_reset_held", 5'h00);
        inRESET_SYNC = 1'b1;
        ra = 4'hC;
        rb = 4'h6;
        iDATA_A = ra;
        iDATA_B = rb;
        @(posedge iCLOCK);
        #1;
        check("after_async_reset", refSum(int'(ra), int'(rb)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
